// File: rtl/fsm_steer_driver.sv
// fsm_steer_driver: initiator-side driver for the 4-state i/j -> x/y Moore FSM
// (states A,B,C,D; outputs A=11, B=01, C=10, D=10).
//
// It accepts a target-state request. It then drives i,j to walk the FSM to that
// state along the shortest path (at most 2 hops). It keeps a shadow copy of the
// FSM state and pulses done on arrival.
//
// Optional feature: define FSM_STEER_CHECK_EN to compare the observed x,y
// against the output the shadow state should produce. A mismatch sets a
// sticky err flag. When the macro is undefined, err is tied low and x,y are
// unused.
//
// Parameters:
//   HOP_LIMIT    - drive cycles allowed in STEER before timeout (2..15)
// Ports:
//   clk          - clock, posedge active
//   rst          - synchronous active-high reset
//   req_valid    - target request valid
//   req_target   - requested state (0=A, 1=B, 2=C, 3=D)
//   req_ready    - driver idle, request accepted when req_valid is high
//   i, j         - FSM inputs; decoded from registered state only
//   x, y         - observed FSM outputs (checked only with FSM_STEER_CHECK_EN)
//   done         - one-cycle pulse, shadow state reached the latched target
//   timeout      - one-cycle pulse, HOP_LIMIT drive cycles used without arrival
//   err          - sticky shadow/FSM output mismatch flag
//   shadow_state - current shadow state, same encoding as req_target
module fsm_steer_driver #(
  parameter int unsigned HOP_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic       i,
  output logic       j,
  input  logic       x,
  input  logic       y,
  output logic       done,
  output logic       timeout,
  output logic       err,
  output logic [1:0] shadow_state
);

  typedef enum logic [0:0] {StIdle, StSteer} mode_e;
  typedef enum logic [1:0] {StA = 2'd0, StB = 2'd1, StC = 2'd2, StD = 2'd3} fsm_state_e;

  localparam logic [3:0] HopLimit = 4'(HOP_LIMIT);

  // Next state of the driven FSM for a given {i,j}.
  function automatic fsm_state_e fsm_next(input fsm_state_e s, input logic [1:0] ij);
    fsm_state_e n;
    unique case (s)
      StA: n = ij[1] ? StB : StA;
      StB: n = ij[1] ? StC : StD;
      StC: n = ij[1] ? StB : (ij[0] ? StC : StD);
      StD: n = ij[1] ? StD : (ij[0] ? StC : StA);
      default: n = StA;
    endcase
    return n;
  endfunction

  // Drive that holds the FSM where it is. B has no self-loop and drifts to D.
  function automatic logic [1:0] park_drive(input fsm_state_e s);
    logic [1:0] d;
    unique case (s)
      StA: d = 2'b00;
      StB: d = 2'b00;
      StC: d = 2'b01;
      StD: d = 2'b10;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // First hop of the shortest path from s toward t.
  function automatic logic [1:0] steer_drive(input fsm_state_e s, input fsm_state_e t);
    logic [1:0] d;
    d = 2'b00;
    unique case (s)
      StA: d = (t == StA) ? 2'b00 : 2'b10;
      StB: d = (t == StC) ? 2'b10 : 2'b00;
      StC: d = (t == StB) ? 2'b10 : 2'b00;
      StD: d = (t == StA) ? 2'b00 : 2'b01;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  mode_e      mode_q;
  fsm_state_e shadow_q;
  fsm_state_e target_q;
  logic [3:0] hop_cnt_q;

  logic       arrived;
  logic       hops_exhausted;
  logic       steering;
  logic [1:0] drive;

  // Everything below decodes registered state only, so i,j carry no input path.
  always_comb begin
    arrived        = (mode_q == StSteer) && (shadow_q == target_q);
    hops_exhausted = (mode_q == StSteer) && !arrived && (hop_cnt_q == HopLimit);
    steering       = (mode_q == StSteer) && !arrived && !hops_exhausted;
    drive          = steering ? steer_drive(shadow_q, target_q) : park_drive(shadow_q);
  end

  assign i            = drive[1];
  assign j            = drive[0];
  assign req_ready    = (mode_q == StIdle);
  assign shadow_state = shadow_q;
  // A reset in the arrival cycle aborts the request, so the pulse is suppressed.
  assign done         = arrived & ~rst;
  assign timeout      = hops_exhausted & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= StIdle;
      shadow_q  <= StA;
      target_q  <= StA;
      hop_cnt_q <= '0;
    end else begin
      // The shadow tracks the FSM using the same i,j that the FSM samples on this edge.
      shadow_q <= fsm_next(shadow_q, drive);
      case (mode_q)
        StIdle: begin
          if (req_valid) begin
            target_q  <= fsm_state_e'(req_target);
            hop_cnt_q <= '0;
            mode_q    <= StSteer;
          end
        end
        StSteer: begin
          if (arrived || hops_exhausted) begin
            mode_q <= StIdle;
          end else begin
            hop_cnt_q <= hop_cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

`ifdef FSM_STEER_CHECK_EN
  logic [1:0] exp_xy;
  logic       err_q;

  always_comb begin
    unique case (shadow_q)
      StA: exp_xy = 2'b11;
      StB: exp_xy = 2'b01;
      StC: exp_xy = 2'b10;
      StD: exp_xy = 2'b10;
      default: exp_xy = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ({x, y} != exp_xy) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_xy;
  assign unused_xy = x ^ y;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_steer_driver.sv
// Testbench for fsm_steer_driver. It contains a behavioural model of the driven
// i/j -> x/y FSM. Directed requests push their expected path into a queue. A
// monitor pops one entry on every done pulse and compares latency, path and
// arrival state.
module tb_fsm_steer_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_target = 2'd0;
  logic       req_ready;
  logic       i;
  logic       j;
  logic       x;
  logic       y;
  logic       done;
  logic       timeout;
  logic       err;
  logic [1:0] shadow_state;

  logic       x_force_low = 1'b0;
  logic [1:0] fsm_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         lat;
    int         hops;
    logic [3:0] ij;
    logic [1:0] state;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fsm_steer_driver #(.HOP_LIMIT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_target   (req_target),
    .req_ready    (req_ready),
    .i            (i),
    .j            (j),
    .x            (x),
    .y            (y),
    .done         (done),
    .timeout      (timeout),
    .err          (err),
    .shadow_state (shadow_state)
  );

  // Reference FSM: A=0, B=1, C=2, D=3; outputs A=11, B=01, C=10, D=10.
  always @(posedge clk) begin
    if (rst) fsm_q <= 2'd0;
    else begin
      case (fsm_q)
        2'd0: fsm_q <= i ? 2'd1 : 2'd0;
        2'd1: fsm_q <= i ? 2'd2 : 2'd3;
        2'd2: fsm_q <= i ? 2'd1 : (j ? 2'd2 : 2'd3);
        default: fsm_q <= i ? 2'd3 : (j ? 2'd2 : 2'd0);
      endcase
    end
  end

  assign x = x_force_low ? 1'b0 : (fsm_q != 2'd1);
  assign y = (fsm_q == 2'd0) || (fsm_q == 2'd1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: follows each accepted request and scores it at its done pulse.
  int         mon_cyc = 0;
  int         mon_hops = 0;
  logic [3:0] mon_ij = 4'd0;
  bit         mon_busy = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
      end else begin
        if (mon_busy) begin
          mon_cyc++;
          if (done) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_done: got done=1, expected no pending request");
            end else begin
              e = exp_q.pop_front();
              check("latency", 32'(mon_cyc), 32'(e.lat));
              check("hop_count", 32'(mon_hops), 32'(e.hops));
              check("ij_path", 32'(mon_ij), 32'(e.ij));
              check("arrival_state", 32'(shadow_state), 32'(e.state));
              check("timeout_with_done", 32'(timeout), 32'd0);
            end
            mon_busy = 1'b0;
          end else begin
            mon_ij = {mon_ij[1:0], i, j};
            mon_hops++;
            if (mon_cyc > 8) begin
              n_cmp++;
              n_bad++;
              $display("FAIL done_missing: got no done after %0d cycles, expected done", mon_cyc);
              mon_busy = 1'b0;
            end
          end
        end else if (done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 while idle, expected 0");
        end
        if (req_valid && req_ready) begin
          mon_busy = 1'b1;
          mon_cyc  = 0;
          mon_hops = 0;
          mon_ij   = 4'd0;
        end
      end
    end
  end

  // Issue one request, then wait (bounded) for its done pulse.
  task automatic request(input logic [1:0] tgt, input int lat, input int hops,
                         input logic [3:0] ij, input logic [1:0] st);
    exp_t e;
    bit   seen;
    e.lat = lat;
    e.hops = hops;
    e.ij = ij;
    e.state = st;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_target = tgt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_wait: got no done within 12 cycles, expected done for target %0d", tgt);
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_shadow", 32'(shadow_state), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_park_ij", 32'({i, j}), 32'd0);

    // A -> C: 10,10 through B.
    request(2'd2, 3, 2, 4'b1010, 2'd2);
    @(negedge clk);
    check("park_c_shadow", 32'(shadow_state), 32'd2);
    check("park_c_ij", 32'({i, j}), 32'b01);

    // C -> A: 00,00 through D, then park holds A.
    request(2'd0, 3, 2, 4'b0000, 2'd0);
    repeat (5) begin
      @(negedge clk);
      check("park_a_shadow", 32'(shadow_state), 32'd0);
      check("park_a_xy", 32'({x, y}), 32'b11);
    end

    // A -> D: 10,00 through B.
    request(2'd3, 3, 2, 4'b1000, 2'd3);

    // D -> B: 01,10 through C; the B park then drifts to D.
    request(2'd1, 3, 2, 4'b0110, 2'd1);
    @(negedge clk);
    check("b_drift_shadow", 32'(shadow_state), 32'd3);
    check("b_drift_xy", 32'({x, y}), 32'b10);

    // D -> A: single hop 00.
    request(2'd0, 2, 1, 4'b0000, 2'd0);

    // A -> A with req_valid held through the done cycle.
    e.lat = 1;
    e.hops = 0;
    e.ij = 4'd0;
    e.state = 2'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_target = 2'd0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("self_done", 32'(done), 32'd1);
    check("self_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("self_ready_back", 32'(req_ready), 32'd1);
    check("self_no_redone", 32'(done), 32'd0);
    @(negedge clk);
    check("self_no_reaccept", 32'(done), 32'd0);

    // Reset in the middle of a request toward D.
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_target = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_hop1_ij", 32'({i, j}), 32'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_shadow_b", 32'(shadow_state), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_ready", 32'(req_ready), 32'd1);
    check("after_rst_shadow", 32'(shadow_state), 32'd0);
    check("after_rst_done", 32'(done), 32'd0);
    check("after_rst_ij", 32'({i, j}), 32'd0);

`ifdef FSM_STEER_CHECK_EN
    check("chk_err_clean", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    x_force_low = 1'b1;
    @(posedge clk);
    #1;
    x_force_low = 1'b0;
    @(negedge clk);
    check("chk_err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    check("chk_err_sticky", 32'(err), 32'd1);
    request(2'd2, 3, 2, 4'b1010, 2'd2);
    check("chk_err_after_steer", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("chk_err_cleared", 32'(err), 32'd0);
`else
    check("err_tied_low", 32'(err), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish by 50000, expected earlier completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fsm_steer_driver.md
Name: fsm_steer_driver

Overview:
- Initiator-side driver for the 4-state i/j → x/y Moore FSM (states A,B,C,D; outputs A=11, B=01, C=10, D=10).
- Accepts a target-state request and generates the i,j stimulus that walks the FSM to that state along the shortest path.
- Keeps a shadow copy of the FSM state and reports arrival. Compiled in, it also checks the FSM's observed x,y against the shadow model.
- Sits between a sequencer/test controller and the FSM instance; both share clk.

Parameters:
- HOP_LIMIT, 3, maximum number of drive cycles in STEER before a timeout is declared (legal range 2..15).

Ports:
- clk  in  1  system clock, posedge active
- rst  in  1  synchronous, active-high reset. The integrator drives the FSM's active-low rstn from the same reset event.
- req_valid  in  1  target request valid
- req_target  in  2  requested state: 0=A, 1=B, 2=C, 3=D
- req_ready  out  1  driver idle and able to accept a request
- i  out  1  FSM input i
- j  out  1  FSM input j
- x  in  1  observed FSM output x
- y  in  1  observed FSM output y
- done  out  1  one-cycle pulse: shadow state equals the latched target
- timeout  out  1  one-cycle pulse: HOP_LIMIT exceeded
- err  out  1  sticky model-mismatch flag
- shadow_state  out  2  current shadow state, same encoding as req_target

Behaviour:
- Reset values: mode=IDLE, shadow=A, target=A, hop_cnt=0, done=0, timeout=0, err=0. req_ready=1 from the first cycle after reset.
- Shadow update: every posedge, shadow ← FSM next-state(shadow, i, j) using the same i,j the FSM samples.
  - A: i→B, else A.
  - B: i→C, else D.
  - C: i→B; !i&j→C; else D.
  - D: i→D; !i&j→C; else A.
- i,j are combinational from registered state only (mode, shadow, target). There is no combinational path from any input to i,j.
- Park drive, used in IDLE and in the done cycle: A=00, B=00 (B cannot hold and moves to D), C=01, D=10.
- Steer drive, next hop toward the target:
  - From A: target B/C/D → 10.
  - From B: target C → 10; target D → 00; target A → 00.
  - From C: target B → 10; target D → 00; target A → 00.
  - From D: target A → 00; target C → 01; target B → 01.
  - Every path is at most 2 hops.
- IDLE:
  - req_ready=1; drive park.
  - On req_valid&req_ready: latch target, hop_cnt←0, go STEER.
  - The park drive applies on the acceptance edge. The path is computed from the shadow state after that edge.
- STEER:
  - req_ready=0; req_valid is ignored.
  - If shadow==target: done=1, drive park, go IDLE next edge.
  - Else if hop_cnt==HOP_LIMIT: timeout=1, drive park, go IDLE.
  - Else: drive steer value, hop_cnt+1.
- Latency: h hops → done is asserted in cycle h+1 after the acceptance edge (h=0 → the first cycle after acceptance).
- done and timeout are never both asserted in the same cycle.
- Reset mid-STEER: return to IDLE and shadow=A; no done or timeout pulse.
- Back-to-back: a new request can be accepted in the cycle after done.

Optional Feature:
- Macro FSM_STEER_CHECK_EN.
- Defined:
  - Every cycle after reset, compare {x,y} with the expected output of the shadow state.
  - On mismatch, set err=1 at the next edge. err is sticky until rst.
  - err does not alter steering.
- Not defined: err is tied to 0 and x,y are unused.

Test Plan:
- Reset, request target=2 (C) with shadow A → drives ij=10,10; shadow A→B→C; done in cycle 3 after acceptance; FSM xy 11→01→10; err=0.
- From C, request target=0 (A) → ij=00,00; path C→D→A; done in cycle 3; xy=11 after arrival; park keeps A for 5 further cycles.
- From D, request target=1 (B) → ij=01,10; D→C→B; done pulse 1 cycle; then park 00 moves to D; shadow_state=3.
- Request target equal to the current state (A→A) → done in cycle 1 after acceptance, no hops; req_valid held high during STEER is not re-accepted until req_ready returns.
- Assert rst in the middle of STEER toward D → next cycle mode IDLE, shadow=A, req_ready=1, no done.
- With FSM_STEER_CHECK_EN, force x=0 for one cycle while shadow=A → err=1 next cycle and stays 1 until rst; steering still completes with done.
